// File: rtl/vec_mem_pkg.sv
// Shared constants, vector type and sequencer state encoding for vector memory ops.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vec_mem_pkg;

  localparam int LANES  = 16;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int REG_W  = 5;
  localparam int CNT_W  = $clog2(LANES);

  typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_WB,
    STORE,
    FINISH
  } seq_state_e;

endpackage

// File: rtl/vec_lane_gather.sv
// Indexed capture register: writes each returning read word into the lane it was issued for.
// Latency: word lands in the buffer two edges after its read is issued (1 memory + 1 capture).
// Backpressure: none; a skipped issue cycle simply produces no capture.
module vec_lane_gather #(
  parameter int LANES  = vec_mem_pkg::LANES,
  parameter int DATA_W = vec_mem_pkg::DATA_W,
  parameter int IDX_W  = $clog2(LANES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cap_en_i,
  input  logic [IDX_W-1:0]             lane_idx_i,
  input  logic [DATA_W-1:0]            rdata_i,
  output logic [LANES-1:0][DATA_W-1:0] lanes_o
);

  logic                         pend_q;
  logic [IDX_W-1:0]             idx_q;
  logic [LANES-1:0][DATA_W-1:0] lanes_q;
  logic [LANES-1:0][DATA_W-1:0] lanes_d;

  // Drop the returning word into the lane that was issued one cycle earlier.
  always_comb begin
    lanes_d = lanes_q;
    if (pend_q) begin
      lanes_d[idx_q] = rdata_i;
    end
  end

  // Track the in-flight read and hold the gathered vector; reset discards partial lanes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q  <= 1'b0;
      idx_q   <= '0;
      lanes_q <= '0;
    end else begin
      pend_q  <= cap_en_i;
      idx_q   <= lane_idx_i;
      lanes_q <= lanes_d;
    end
  end

  assign lanes_o = lanes_q;

endmodule

// File: rtl/vec_mem_sequencer.sv
// Moves one full vector between the scalar data-memory port and the vector register file.
// Latency: load done 18 cycles after start, store done 17, each stall cycle in LOAD/STORE adds one.
// Backpressure: stall suppresses strobes and freezes the lane counter; start ignored while busy.
module vec_mem_sequencer #(
  parameter int LANES  = vec_mem_pkg::LANES,
  parameter int DATA_W = vec_mem_pkg::DATA_W,
  parameter int ADDR_W = vec_mem_pkg::ADDR_W,
  parameter int REG_W  = vec_mem_pkg::REG_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         is_store,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [REG_W-1:0]             rd,
  input  logic [LANES-1:0][DATA_W-1:0] store_data,
  input  logic                         stall,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_re,
  output logic                         mem_we,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         vreg_we,
  output logic [REG_W-1:0]             vreg_waddr,
  output logic [LANES-1:0][DATA_W-1:0] vreg_wdata,
  output logic                         busy,
  output logic                         done
);

  import vec_mem_pkg::*;

  localparam int CW = $clog2(LANES);

  seq_state_e                   state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [ADDR_W-1:0]            base_q, base_d;
  logic [REG_W-1:0]             rd_q, rd_d;
  logic                         store_q, store_d;
  logic [LANES-1:0][DATA_W-1:0] sdata_q, sdata_d;
  logic                         last_lane;
  logic [ADDR_W-1:0]            lane_addr;

  assign last_lane = (cnt_q == CW'(LANES - 1));
  // Address arithmetic truncates to ADDR_W, so the top of memory wraps to 0.
  assign lane_addr = base_q + ADDR_W'(cnt_q);

  // Next-state, lane counter and strobe decode; strobes only fire on non-stalled cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    rd_d    = rd_q;
    store_d = store_q;
    sdata_d = sdata_q;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    done    = 1'b0;
    vreg_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          rd_d    = rd;
          store_d = is_store;
          sdata_d = store_data;
          cnt_d   = '0;
          state_d = is_store ? STORE : LOAD;
        end
      end
      LOAD: begin
        if (!stall) begin
          mem_re = 1'b1;
          if (last_lane) state_d = LOAD_WB;
          else           cnt_d   = cnt_q + CW'(1);
        end
      end
      LOAD_WB: begin
        state_d = FINISH;
      end
      STORE: begin
        if (!stall) begin
          mem_we = 1'b1;
          if (last_lane) state_d = FINISH;
          else           cnt_d   = cnt_q + CW'(1);
        end
      end
      FINISH: begin
        done    = 1'b1;
        vreg_we = !store_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched request; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      rd_q    <= '0;
      store_q <= 1'b0;
      sdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      rd_q    <= rd_d;
      store_q <= store_d;
      sdata_q <= sdata_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign mem_addr   = (mem_re || mem_we) ? lane_addr : '0;
  assign mem_wdata  = mem_we ? sdata_q[cnt_q] : '0;
  assign vreg_waddr = rd_q;

  vec_lane_gather #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .IDX_W  (CW)
  ) u_gather (
    .clk        (clk),
    .rst        (rst),
    .cap_en_i   (mem_re),
    .lane_idx_i (cnt_q),
    .rdata_i    (mem_rdata),
    .lanes_o    (vreg_wdata)
  );

endmodule
